// File: rtl/ex_mem_pkg.sv
// Shared constants, bus widths and the execute-to-memory payload for the EX/MEM pipeline register.
package ex_mem_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned CNT_W   = 2;

    // Positions of the execute and memory stages in the stall vector.
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;

    localparam logic [DATA_W-1:0] ZeroWord    = DATA_W'(0);
    localparam logic [ADDR_W-1:0] NOPRegAddr  = ADDR_W'(0);
    localparam logic [OP_W-1:0]   EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [OP_W-1:0]   EXE_MADD_OP = 8'b1010_0110;
    localparam logic [OP_W-1:0]   EXE_MSUB_OP = 8'b1010_1010;

    typedef logic [DATA_W-1:0]   reg_bus_t;
    typedef logic [ADDR_W-1:0]   reg_addr_bus_t;
    typedef logic [OP_W-1:0]     alu_op_bus_t;
    typedef logic [2*DATA_W-1:0] double_reg_bus_t;

    // Everything the memory stage receives from execute.
    typedef struct packed {
        reg_addr_bus_t wd;
        logic          wreg;
        reg_bus_t      wdata;
        reg_bus_t      hi;
        reg_bus_t      lo;
        logic          whilo;
        alu_op_bus_t   aluop;
        reg_bus_t      mem_addr;
        reg_bus_t      reg2;
    } mem_bus_t;

    // Payload of a pipeline bubble: no register or HI/LO write, NOP op.
    function automatic mem_bus_t nop_bus();
        mem_bus_t b;
        b.wd       = NOPRegAddr;
        b.wreg     = WriteDisable;
        b.wdata    = ZeroWord;
        b.hi       = ZeroWord;
        b.lo       = ZeroWord;
        b.whilo    = WriteDisable;
        b.aluop    = EXE_NOP_OP;
        b.mem_addr = ZeroWord;
        b.reg2     = ZeroWord;
        return b;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_ctl.sv
// Decodes flush and the ex/mem stall bits into a one-hot pipeline-register action.
module ex_mem_pipe_reg_ctl (
    input  logic flush_i,
    input  logic stall_ex_i,
    input  logic stall_mem_i,
    output logic advance_c_o,
    output logic bubble_c_o,
    output logic hold_c_o,
    output logic clear_c_o
);

    // Flush dominates; ex stalled alone inserts a bubble, ex and mem stalled freeze the register.
    always_comb begin
        clear_c_o   = flush_i;
        bubble_c_o  = !flush_i && stall_ex_i && !stall_mem_i;
        hold_c_o    = !flush_i && stall_ex_i && stall_mem_i;
        advance_c_o = !flush_i && !stall_ex_i;
    end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries execute results to the memory stage and holds
// the MADD/MSUB partial product and cycle count across the execute stall.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [OP_W-1:0]       ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   hilo_temp_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [OP_W-1:0]       mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_temp_o,
    output logic [CNT_W-1:0]      cnt_o
);

    logic advance_c, bubble_c, hold_c, clear_c;
    mem_bus_t        ex_bus_c;
    mem_bus_t        mem_q, mem_d;
    double_reg_bus_t hilo_q, hilo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    ex_mem_pipe_reg_ctl u_ctl (
        .flush_i     (flush),
        .stall_ex_i  (stall[STALL_EX]),
        .stall_mem_i (stall[STALL_MEM]),
        .advance_c_o (advance_c),
        .bubble_c_o  (bubble_c),
        .hold_c_o    (hold_c),
        .clear_c_o   (clear_c)
    );

    // Hold is the default action; the other stall bits belong to other stages.
    logic unused_c;
    assign unused_c = ^{hold_c, stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

    always_comb begin
        ex_bus_c.wd       = ex_wd;
        ex_bus_c.wreg     = ex_wreg;
        ex_bus_c.wdata    = ex_wdata;
        ex_bus_c.hi       = ex_hi;
        ex_bus_c.lo       = ex_lo;
        ex_bus_c.whilo    = ex_whilo;
        ex_bus_c.aluop    = ex_aluop;
        ex_bus_c.mem_addr = ex_mem_addr;
        ex_bus_c.reg2     = ex_reg2;
    end

    // Next-state selection; the MADD/MSUB feedback only survives a bubble.
    always_comb begin
        mem_d  = mem_q;
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
        if (clear_c) begin
            mem_d  = nop_bus();
            hilo_d = '0;
            cnt_d  = '0;
        end else if (bubble_c) begin
            mem_d  = nop_bus();
            hilo_d = hilo_temp_i;
            cnt_d  = cnt_i;
        end else if (advance_c) begin
            mem_d  = ex_bus_c;
            hilo_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            mem_q  <= nop_bus();
            hilo_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            hilo_q <= hilo_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mem_wd       = mem_q.wd;
    assign mem_wreg     = mem_q.wreg;
    assign mem_wdata    = mem_q.wdata;
    assign mem_hi       = mem_q.hi;
    assign mem_lo       = mem_q.lo;
    assign mem_whilo    = mem_q.whilo;
    assign mem_aluop    = mem_q.aluop;
    assign mem_mem_addr = mem_q.mem_addr;
    assign mem_reg2     = mem_q.reg2;
    assign hilo_temp_o  = hilo_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: a driver pushes expected outputs per edge, a monitor pops and compares.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic        ex_whilo;
    logic [7:0]  ex_aluop;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;

    typedef struct packed {
        logic        flush;
        logic [5:0]  stall;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } in_t;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } exp_t;

    exp_t model;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".mem_wd"},       64'(mem_wd),       64'(e.wd));
        check({tag, ".mem_wreg"},     64'(mem_wreg),     64'(e.wreg));
        check({tag, ".mem_wdata"},    64'(mem_wdata),    64'(e.wdata));
        check({tag, ".mem_hi"},       64'(mem_hi),       64'(e.hi));
        check({tag, ".mem_lo"},       64'(mem_lo),       64'(e.lo));
        check({tag, ".mem_whilo"},    64'(mem_whilo),    64'(e.whilo));
        check({tag, ".mem_aluop"},    64'(mem_aluop),    64'(e.aluop));
        check({tag, ".mem_mem_addr"}, 64'(mem_mem_addr), 64'(e.addr));
        check({tag, ".mem_reg2"},     64'(mem_reg2),     64'(e.reg2));
        check({tag, ".hilo_temp_o"},  hilo_temp_o,       e.hilo);
        check({tag, ".cnt_o"},        64'(cnt_o),        64'(e.cnt));
    endtask

    // Reference behaviour of one rising edge, straight from the stage rules.
    function automatic exp_t next_model(input exp_t cur, input in_t v);
        exp_t n;
        n = cur;
        if (v.flush) begin
            n = '0;
        end else if (!v.stall[3]) begin
            n = '{wd: v.wd, wreg: v.wreg, wdata: v.wdata, hi: v.hi, lo: v.lo, whilo: v.whilo,
                  aluop: v.aluop, addr: v.addr, reg2: v.reg2, hilo: 64'd0, cnt: 2'd0};
        end else if (!v.stall[4]) begin
            n = '0;
            n.hilo = v.hilo;
            n.cnt  = v.cnt;
        end
        return n;
    endfunction

    // Drive one cycle of inputs on the falling edge and queue the expected post-edge state.
    task automatic apply(input in_t v);
        @(negedge clk);
        rst         = 1'b0;
        flush       = v.flush;
        stall       = v.stall;
        ex_wd       = v.wd;
        ex_wreg     = v.wreg;
        ex_wdata    = v.wdata;
        ex_hi       = v.hi;
        ex_lo       = v.lo;
        ex_whilo    = v.whilo;
        ex_aluop    = v.aluop;
        ex_mem_addr = v.addr;
        ex_reg2     = v.reg2;
        hilo_temp_i = v.hilo;
        cnt_i       = v.cnt;
        a_stall_monotone: assert (!(v.stall[4] && !v.stall[3]));
        model = next_model(model, v);
        q.push_back(model);
    endtask

    function automatic in_t rand_in();
        in_t v;
        int k;
        k = $urandom_range(0, 6);
        v.flush = ($urandom_range(0, 9) == 0);
        v.stall = 6'((32'd1 << k) - 32'd1);
        v.wd    = 5'($urandom);
        v.wreg  = 1'($urandom);
        v.wdata = $urandom;
        v.hi    = $urandom;
        v.lo    = $urandom;
        v.whilo = 1'($urandom);
        v.aluop = 8'($urandom);
        v.addr  = $urandom;
        v.reg2  = $urandom;
        v.hilo  = {$urandom, $urandom};
        v.cnt   = 2'($urandom_range(0, 3));
        return v;
    endfunction

    // Raise rst between edges and expect every output to clear without waiting for a clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        model = '0;
        check_all(tag, model);
    endtask

    // Monitor: every rising edge produces one output word to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_all("pipe", e);
            end
        end
    end

    initial begin
        in_t v;
        rst = 1'b1; flush = 1'b0; stall = '0;
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
        ex_whilo = 1'b0; ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0;
        hilo_temp_i = '0; cnt_i = '0;
        model = '0;
        #12;
        check_all("reset", model);

        // Advance with a GPR write.
        v = '0; v.wd = 5'd5; v.wreg = 1'b1; v.wdata = 32'hDEADBEEF; v.aluop = 8'h21;
        apply(v);

        // MADD: bubble holds the partial product, then the release latches HI/LO.
        v = '0; v.stall = 6'b001111; v.hilo = 64'h00000001_FFFFFFFE; v.cnt = 2'd1;
        v.wreg = 1'b1; v.wd = 5'd9; v.wdata = 32'h55; v.aluop = 8'hA6;
        apply(v);
        v = '0; v.whilo = 1'b1; v.hi = 32'h00000002; v.lo = 32'h0000000B; v.cnt = 2'd2;
        v.aluop = 8'hA6; v.hilo = 64'hFFFF_0000_FFFF_0000;
        apply(v);

        // Hold keeps the previous contents while ex_* inputs wander.
        v = '0; v.wdata = 32'hA5A5A5A5; v.wreg = 1'b1; v.wd = 5'd17;
        apply(v);
        for (int i = 0; i < 3; i++) begin
            v = rand_in(); v.flush = 1'b0; v.stall = 6'b011111;
            apply(v);
        end

        // Flush wins over a bubble carrying MADD state.
        v = rand_in(); v.flush = 1'b1; v.stall = 6'b001111; v.cnt = 2'd1;
        apply(v);

        // HI/LO path.
        v = '0; v.whilo = 1'b1; v.hi = 32'h11111111; v.lo = 32'h22222222;
        apply(v);

        // Asynchronous reset with live contents, then mid-MADD.
        v = '0; v.wdata = 32'h00001234; v.wreg = 1'b1;
        apply(v);
        async_reset("async_rst");
        v = rand_in(); v.flush = 1'b0; v.stall = 6'b001111; v.cnt = 2'd1;
        apply(v);
        async_reset("madd_rst");

        for (int i = 0; i < 400; i++) begin
            apply(rand_in());
        end

        @(posedge clk);
        #3;
        check("drain", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
